// File: rtl/uart_host_ctrl_if.sv
// Single-beat command/response channel between a host (soft core or FSM) and uart_host_ctrl.
interface uart_host_ctrl_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [7:0] cmd_wdata;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       rsp_err;

    modport master (
        output cmd_valid, cmd_op, cmd_wdata,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_wdata,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/uart_host_ctrl.sv
// Bus initiator for the UART parallel CPU port: turns host commands into timed n_CS/n_RD/n_WR cycles,
// waits on Tx_RDY/Rx_RDY with timeout and optionally programs the control register after reset.
//
//  state  | meaning
//  INIT   | one idle cycle after reset, then the INIT_CR control write (no response)
//  IDLE   | cmd_ready high, waiting for a command
//  WAIT   | data op waiting on Tx_RDY/Rx_RDY, bounded by TIMEOUT
//  SETUP  | n_CS low, C_nD/DATA_IN stable, strobes high
//  STROBE | n_WR or n_RD low; reads capture DATA_OUT on the last cycle
//  HOLD   | strobe released, n_CS low, C_nD/DATA_IN held
//  RESP   | one-cycle rsp_valid
module uart_host_ctrl #(
    parameter int         SETUP_CYC  = 1,
    parameter int         STROBE_CYC = 2,
    parameter int         HOLD_CYC   = 1,
    parameter int         TIMEOUT    = 1000,
    parameter int         INIT_EN    = 1,
    parameter logic [7:0] INIT_CR    = 8'h00
) (
    input  logic              CLK50MHZ,
    input  logic              n_RST,
    uart_host_ctrl_if.slave   host,
    output logic              busy,
    output logic              uart_n_CS,
    output logic              uart_C_nD,
    output logic              uart_n_RD,
    output logic              uart_n_WR,
    output logic [7:0]        uart_DATA_IN,
    input  logic [7:0]        uart_DATA_OUT,
    input  logic              uart_Tx_RDY,
    input  logic              uart_Rx_RDY
);

    localparam int PMAX_SS = (SETUP_CYC > STROBE_CYC) ? SETUP_CYC : STROBE_CYC;
    localparam int PMAX    = (PMAX_SS > HOLD_CYC) ? PMAX_SS : HOLD_CYC;
    localparam int CW      = $clog2(PMAX) + 1;
    localparam int TW      = $clog2(TIMEOUT + 1) + 1;

    localparam logic [CW-1:0] SETUP_LD  = CW'(SETUP_CYC - 1);
    localparam logic [CW-1:0] STROBE_LD = CW'(STROBE_CYC - 1);
    localparam logic [CW-1:0] HOLD_LD   = CW'(HOLD_CYC - 1);
    localparam logic [TW-1:0] WAIT_LD   = (TIMEOUT == 0) ? TW'(0) : TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_INIT, S_IDLE, S_WAIT, S_SETUP, S_STROBE, S_HOLD, S_RESP
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] phase_cnt_q, phase_cnt_d;
    logic [TW-1:0] wait_cnt_q, wait_cnt_d;
    logic [1:0]    op_q, op_d;
    logic [7:0]    wdata_q, wdata_d;
    logic          init_q, init_d;
    logic          err_q, err_d;

    logic          cmd_ready_q, rsp_valid_q, rsp_err_q, busy_q;
    logic [7:0]    rsp_rdata_q;
    logic          n_cs_q, c_nd_q, n_rd_q, n_wr_q;
    logic [7:0]    data_in_q;

    logic          cmd_ready_d, rsp_valid_d, rsp_err_d, busy_d;
    logic [7:0]    rsp_rdata_d;
    logic          n_cs_d, c_nd_d, n_rd_d, n_wr_d;
    logic [7:0]    data_in_d;

    logic          accept;
    logic          cmd_rdy_in;
    logic          wait_rdy_in;
    logic          in_bus;

    assign cmd_rdy_in  = host.cmd_op[1] ? uart_Rx_RDY : uart_Tx_RDY;
    assign wait_rdy_in = op_q[1] ? uart_Rx_RDY : uart_Tx_RDY;

    always_ff @(posedge CLK50MHZ or negedge n_RST) begin
        if (!n_RST) begin
            state_q     <= (INIT_EN != 0) ? S_INIT : S_IDLE;
            phase_cnt_q <= '0;
            wait_cnt_q  <= '0;
            op_q        <= 2'b01;
            wdata_q     <= 8'h00;
            init_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_cnt_q <= phase_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            op_q        <= op_d;
            wdata_q     <= wdata_d;
            init_q      <= init_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        phase_cnt_d = phase_cnt_q;
        wait_cnt_d  = wait_cnt_q;
        op_d        = op_q;
        wdata_d     = wdata_q;
        init_d      = init_q;
        err_d       = err_q;
        accept      = 1'b0;
        case (state_q)
            S_INIT: begin
                op_d        = 2'b01;
                wdata_d     = INIT_CR;
                init_d      = 1'b1;
                err_d       = 1'b0;
                state_d     = S_SETUP;
                phase_cnt_d = SETUP_LD;
            end
            S_IDLE: begin
                if (host.cmd_valid) begin
                    accept  = 1'b1;
                    op_d    = host.cmd_op;
                    wdata_d = host.cmd_wdata;
                    init_d  = 1'b0;
                    err_d   = 1'b0;
                    // data ops whose ready is already up skip WAIT so they get the no-wait latency
                    if (!host.cmd_op[0] && !cmd_rdy_in) begin
                        state_d    = S_WAIT;
                        wait_cnt_d = WAIT_LD;
                    end else begin
                        state_d     = S_SETUP;
                        phase_cnt_d = SETUP_LD;
                    end
                end
            end
            S_WAIT: begin
                if (wait_rdy_in) begin
                    state_d     = S_SETUP;
                    phase_cnt_d = SETUP_LD;
                end else if (TIMEOUT != 0 && wait_cnt_q == '0) begin
                    state_d = S_RESP;
                    err_d   = 1'b1;
                end else if (wait_cnt_q != '0) begin
                    wait_cnt_d = wait_cnt_q - TW'(1);
                end
            end
            S_SETUP: begin
                if (phase_cnt_q == '0) begin
                    state_d     = S_STROBE;
                    phase_cnt_d = STROBE_LD;
                end else begin
                    phase_cnt_d = phase_cnt_q - CW'(1);
                end
            end
            S_STROBE: begin
                if (phase_cnt_q == '0) begin
                    state_d     = S_HOLD;
                    phase_cnt_d = HOLD_LD;
                end else begin
                    phase_cnt_d = phase_cnt_q - CW'(1);
                end
            end
            S_HOLD: begin
                if (phase_cnt_q == '0) begin
                    state_d = init_q ? S_IDLE : S_RESP;
                end else begin
                    phase_cnt_d = phase_cnt_q - CW'(1);
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // outputs are decoded from the next state so that every pin comes straight from a flop
    always_comb begin
        in_bus      = (state_d == S_SETUP) || (state_d == S_STROBE) || (state_d == S_HOLD);
        n_cs_d      = !in_bus;
        c_nd_d      = in_bus ? op_d[0] : 1'b1;
        data_in_d   = (in_bus && !op_d[1]) ? wdata_d : 8'h00;
        n_wr_d      = !((state_d == S_STROBE) && !op_d[1]);
        n_rd_d      = !((state_d == S_STROBE) && op_d[1]);
        cmd_ready_d = (state_d == S_IDLE);
        rsp_valid_d = (state_d == S_RESP);
        rsp_err_d   = (state_d == S_RESP) && err_d;
        busy_d      = (state_d != S_IDLE);
        rsp_rdata_d = rsp_rdata_q;
        if (accept) begin
            rsp_rdata_d = 8'h00;
        end else if (state_q == S_STROBE && phase_cnt_q == '0 && op_q[1]) begin
            rsp_rdata_d = uart_DATA_OUT;
        end
    end

    always_ff @(posedge CLK50MHZ or negedge n_RST) begin
        if (!n_RST) begin
            n_cs_q      <= 1'b1;
            c_nd_q      <= 1'b1;
            n_rd_q      <= 1'b1;
            n_wr_q      <= 1'b1;
            data_in_q   <= 8'h00;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 8'h00;
            rsp_err_q   <= 1'b0;
            busy_q      <= (INIT_EN != 0);
        end else begin
            n_cs_q      <= n_cs_d;
            c_nd_q      <= c_nd_d;
            n_rd_q      <= n_rd_d;
            n_wr_q      <= n_wr_d;
            data_in_q   <= data_in_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            busy_q      <= busy_d;
        end
    end

    assign uart_n_CS      = n_cs_q;
    assign uart_C_nD      = c_nd_q;
    assign uart_n_RD      = n_rd_q;
    assign uart_n_WR      = n_wr_q;
    assign uart_DATA_IN   = data_in_q;
    assign host.cmd_ready = cmd_ready_q;
    assign host.rsp_valid = rsp_valid_q;
    assign host.rsp_rdata = rsp_rdata_q;
    assign host.rsp_err   = rsp_err_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_uart_host_ctrl.sv
// Scoreboard bench for uart_host_ctrl: stimulus pushes expected bus cycles and responses,
// independent monitors pop and compare as the DUT produces them.
module tb_uart_host_ctrl;

    typedef struct {
        logic       c_nd;
        logic [7:0] data;
        int         wr_len;
        int         rd_len;
        int         cs_len;
    } bus_exp_t;

    typedef struct {
        logic [7:0] rdata;
        logic       err;
        int         acc;
        int         lat;
    } rsp_exp_t;

    logic       clk = 1'b0;
    logic       n_RST;
    always #10 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    uart_host_ctrl_if h ();
    uart_host_ctrl_if ht ();

    logic       busy, n_cs, c_nd, n_rd, n_wr;
    logic [7:0] data_in, data_out;
    logic       tx_rdy, rx_rdy;
    logic       t_busy, t_n_cs, t_c_nd, t_n_rd, t_n_wr;
    logic [7:0] t_data_in;

    uart_host_ctrl #(.INIT_CR(8'h3A)) dut (
        .CLK50MHZ(clk), .n_RST(n_RST), .host(h), .busy(busy),
        .uart_n_CS(n_cs), .uart_C_nD(c_nd), .uart_n_RD(n_rd), .uart_n_WR(n_wr),
        .uart_DATA_IN(data_in), .uart_DATA_OUT(data_out),
        .uart_Tx_RDY(tx_rdy), .uart_Rx_RDY(rx_rdy)
    );

    uart_host_ctrl #(.TIMEOUT(8), .INIT_CR(8'h00)) dut_to (
        .CLK50MHZ(clk), .n_RST(n_RST), .host(ht), .busy(t_busy),
        .uart_n_CS(t_n_cs), .uart_C_nD(t_c_nd), .uart_n_RD(t_n_rd), .uart_n_WR(t_n_wr),
        .uart_DATA_IN(t_data_in), .uart_DATA_OUT(8'h00),
        .uart_Tx_RDY(1'b0), .uart_Rx_RDY(1'b0)
    );

    int n_chk = 0;
    int n_pass = 0;
    bus_exp_t bus_q[$];
    rsp_exp_t rsp_q[$];
    rsp_exp_t rsp_to_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic bus_exp_t mk_bus(input logic cnd, input logic [7:0] d, input int wl, input int rl);
        bus_exp_t b;
        b.c_nd = cnd; b.data = d; b.wr_len = wl; b.rd_len = rl; b.cs_len = 4;
        return b;
    endfunction

    // response monitor, main DUT
    always @(negedge clk) begin : rsp_mon
        rsp_exp_t e;
        if (n_RST && h.rsp_valid) begin
            if (rsp_q.size() == 0) begin
                n_chk++;
                $display("FAIL rsp_unexpected: rsp_valid with no outstanding command, rdata %0h err %0b",
                         h.rsp_rdata, h.rsp_err);
            end else begin
                e = rsp_q.pop_front();
                chk("rsp_rdata", 32'(h.rsp_rdata), 32'(e.rdata));
                chk("rsp_err", 32'(h.rsp_err), 32'(e.err));
                if (e.lat > 0) chk("rsp_latency", 32'(cyc - e.acc + 1), 32'(e.lat));
            end
        end
    end

    // response monitor, timeout DUT
    always @(negedge clk) begin : rsp_to_mon
        rsp_exp_t e;
        if (n_RST && ht.rsp_valid) begin
            if (rsp_to_q.size() == 0) begin
                n_chk++;
                $display("FAIL to_rsp_unexpected: rsp_valid with no outstanding command, err %0b", ht.rsp_err);
            end else begin
                e = rsp_to_q.pop_front();
                chk("to_rsp_rdata", 32'(ht.rsp_rdata), 32'(e.rdata));
                chk("to_rsp_err", 32'(ht.rsp_err), 32'(e.err));
                chk("to_rsp_latency", 32'(cyc - e.acc + 1), 32'(e.lat));
            end
        end
    end

    bit to_watch = 1'b0;
    int to_cs_low = 0;
    always @(negedge clk) if (n_RST && to_watch && !t_n_cs) to_cs_low++;

    // bus-cycle monitor: measures each n_CS-low window and compares with the expected cycle
    bit         bm_in = 1'b0, bm_gap_ok = 1'b0, bm_viol = 1'b0, bm_stable = 1'b1;
    int         bm_cs = 0, bm_wr = 0, bm_rd = 0, bm_gap = 0;
    logic       bm_cnd;
    logic [7:0] bm_d;
    always @(negedge clk) begin : bus_mon
        bus_exp_t e;
        if (!n_RST) begin
            bm_in = 1'b0; bm_gap_ok = 1'b0; bm_viol = 1'b0;
        end else begin
            if (!n_wr && !n_rd) bm_viol = 1'b1;
            if (n_cs && (!n_wr || !n_rd)) bm_viol = 1'b1;
            if (!n_cs) begin
                if (!bm_in) begin
                    bm_in = 1'b1; bm_cs = 0; bm_wr = 0; bm_rd = 0;
                    bm_cnd = c_nd; bm_d = data_in; bm_stable = 1'b1;
                    if (bm_gap_ok) chk("cs_gap_ge2", 32'(bm_gap >= 2), 32'd1);
                end
                bm_cs++;
                if (!n_wr) bm_wr++;
                if (!n_rd) bm_rd++;
                if (c_nd !== bm_cnd || data_in !== bm_d) bm_stable = 1'b0;
            end else begin
                if (bm_in) begin
                    bm_in = 1'b0;
                    if (bus_q.size() == 0) begin
                        n_chk++;
                        $display("FAIL bus_unexpected: bus cycle c_nd %0b data %0h wr %0d rd %0d",
                                 bm_cnd, bm_d, bm_wr, bm_rd);
                    end else begin
                        e = bus_q.pop_front();
                        chk("bus_c_nd", 32'(bm_cnd), 32'(e.c_nd));
                        chk("bus_data", 32'(bm_d), 32'(e.data));
                        chk("bus_wr_len", 32'(bm_wr), 32'(e.wr_len));
                        chk("bus_rd_len", 32'(bm_rd), 32'(e.rd_len));
                        chk("bus_cs_len", 32'(bm_cs), 32'(e.cs_len));
                        chk("bus_stable", 32'(bm_stable), 32'd1);
                        chk("bus_protocol", 32'(bm_viol), 32'd0);
                    end
                    bm_viol = 1'b0; bm_gap = 0; bm_gap_ok = 1'b1;
                end
                bm_gap++;
            end
        end
    end

    task automatic send(input logic [1:0] op, input logic [7:0] wd, input bit track,
                        input bus_exp_t be, input logic [7:0] exp_rd, input logic exp_err, input int lat);
        rsp_exp_t r;
        int budget = 0;
        @(negedge clk);
        h.cmd_valid = 1'b1; h.cmd_op = op; h.cmd_wdata = wd;
        while (!h.cmd_ready && budget < 200) begin
            @(negedge clk);
            budget++;
        end
        if (!h.cmd_ready) begin
            chk("cmd_accept_timeout", 32'(h.cmd_ready), 32'd1);
            h.cmd_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        h.cmd_valid = 1'b0;
        if (track) begin
            r.rdata = exp_rd; r.err = exp_err; r.acc = cyc; r.lat = lat;
            bus_q.push_back(be);
            rsp_q.push_back(r);
        end
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((bus_q.size() != 0 || rsp_q.size() != 0 || rsp_to_q.size() != 0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        chk({name, "_bus_left"}, 32'(bus_q.size()), 32'd0);
        chk({name, "_rsp_left"}, 32'(rsp_q.size() + rsp_to_q.size()), 32'd0);
    endtask

    task automatic wait_ready(input string name);
        int n = 0;
        while (!h.cmd_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk(name, 32'(h.cmd_ready), 32'd1);
    endtask

    bus_exp_t none;
    rsp_exp_t rt;

    initial begin
        n_RST = 1'b0;
        h.cmd_valid = 1'b0; h.cmd_op = 2'b00; h.cmd_wdata = 8'h00;
        ht.cmd_valid = 1'b0; ht.cmd_op = 2'b00; ht.cmd_wdata = 8'h00;
        tx_rdy = 1'b0; rx_rdy = 1'b0; data_out = 8'h00;
        none = mk_bus(1'b0, 8'h00, 0, 0);
        repeat (2) @(negedge clk);

        chk("rst_n_cs", 32'(n_cs), 32'd1);
        chk("rst_n_wr", 32'(n_wr), 32'd1);
        chk("rst_n_rd", 32'(n_rd), 32'd1);
        chk("rst_c_nd", 32'(c_nd), 32'd1);
        chk("rst_data_in", 32'(data_in), 32'd0);
        chk("rst_cmd_ready", 32'(h.cmd_ready), 32'd0);
        chk("rst_rsp_valid", 32'(h.rsp_valid), 32'd0);
        chk("rst_rsp_rdata", 32'(h.rsp_rdata), 32'd0);
        chk("rst_rsp_err", 32'(h.rsp_err), 32'd0);
        chk("rst_busy", 32'(busy), 32'd1);

        // init write of INIT_CR
        bus_q.push_back(mk_bus(1'b1, 8'h3A, 2, 0));
        n_RST = 1'b1;
        wait_ready("init_cmd_ready");
        drain("init");
        chk("idle_busy", 32'(busy), 32'd0);

        // data write with Tx_RDY already high
        tx_rdy = 1'b1;
        send(2'b00, 8'h55, 1'b1, mk_bus(1'b0, 8'h55, 2, 0), 8'h00, 1'b0, 5);
        drain("wr_data");

        // data read waiting on Rx_RDY
        tx_rdy = 1'b0;
        send(2'b10, 8'hEE, 1'b1, mk_bus(1'b0, 8'h00, 0, 2), 8'hC3, 1'b0, 0);
        repeat (20) @(negedge clk);
        chk("rd_wait_no_cs", 32'(n_cs), 32'd1);
        chk("rd_wait_busy", 32'(busy), 32'd1);
        data_out = 8'hC3;
        rx_rdy = 1'b1;
        drain("rd_data");
        rx_rdy = 1'b0;

        // status read ignores Rx_RDY
        data_out = 8'h81;
        send(2'b11, 8'h00, 1'b1, mk_bus(1'b1, 8'h00, 0, 2), 8'h81, 1'b0, 5);
        drain("rd_status");

        // back-to-back control write then status read
        send(2'b01, 8'h1F, 1'b1, mk_bus(1'b1, 8'h1F, 2, 0), 8'h00, 1'b0, 5);
        data_out = 8'h42;
        send(2'b11, 8'h00, 1'b1, mk_bus(1'b1, 8'h00, 0, 2), 8'h42, 1'b0, 5);
        drain("b2b");

        // timeout on the TIMEOUT=8 instance
        begin
            int n = 0;
            while (!ht.cmd_ready && n < 100) begin
                @(negedge clk);
                n++;
            end
            chk("to_cmd_ready", 32'(ht.cmd_ready), 32'd1);
            to_watch = 1'b1;
            ht.cmd_valid = 1'b1; ht.cmd_op = 2'b00; ht.cmd_wdata = 8'h77;
            @(posedge clk);
            #1;
            ht.cmd_valid = 1'b0;
            rt.rdata = 8'h00; rt.err = 1'b1; rt.acc = cyc; rt.lat = 9;
            rsp_to_q.push_back(rt);
            drain("timeout");
            chk("to_cs_never_low", 32'(to_cs_low), 32'd0);
            to_watch = 1'b0;
        end

        // async reset in the middle of a write strobe
        tx_rdy = 1'b1;
        send(2'b00, 8'hAA, 1'b0, none, 8'h00, 1'b0, 0);
        @(posedge clk);
        #2;
        chk("rst_mid_pre_n_wr", 32'(n_wr), 32'd0);
        n_RST = 1'b0;
        #1;
        chk("rst_mid_n_wr", 32'(n_wr), 32'd1);
        chk("rst_mid_n_cs", 32'(n_cs), 32'd1);
        chk("rst_mid_rsp_valid", 32'(h.rsp_valid), 32'd0);
        repeat (2) @(negedge clk);
        bus_q.push_back(mk_bus(1'b1, 8'h3A, 2, 0));
        n_RST = 1'b1;
        wait_ready("reinit_cmd_ready");
        drain("reinit");

        send(2'b00, 8'hA5, 1'b1, mk_bus(1'b0, 8'hA5, 2, 0), 8'h00, 1'b0, 5);
        drain("post_rst_wr");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
